// File: rtl/regfile_write_decoder_if.sv
// regfile_write_decoder_if: valid/ready write-back bundle into the register bank
interface regfile_write_decoder_if #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
);
  logic              wr_valid;
  logic              wr_ready;
  logic [AWIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  modport master(output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave(input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_decoder.sv
// regfile_write_decoder: decoded register-bank write port with r0 hardwired and a sequential clear
module regfile_write_decoder #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  regfile_write_decoder_if.slave        wb,
  input  logic                          clr_start,
  output logic                          busy,
  output logic                          zero_wr,
  output logic [7:0]                    wr_count,
  output logic [WIDTH*(2**AWIDTH)-1:0]  regs_flat
);
  localparam int NREG = 2**AWIDTH;
  localparam logic [AWIDTH-1:0] LAST = '1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state;
  logic [AWIDTH-1:0] cnt;
  logic              accept;
  logic [NREG-1:0]   wen;
  assign wb.wr_ready = state == IDLE;
  assign busy        = state == CLEAR;
  assign accept      = wb.wr_valid && wb.wr_ready;
  assign wen         = accept ? {{(NREG-1){1'b0}}, 1'b1} << wb.wr_addr : '0;
  // Sequencer: clear walks 1..LAST and wraps the counter back to 0 on its own; also tracks write stats
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      zero_wr  <= 1'b0;
      wr_count <= '0;
    end else begin
      zero_wr <= wen[0];
      if (accept && wb.wr_addr != '0 && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      if (state == IDLE && clr_start) begin
        state <= CLEAR;
        cnt   <= AWIDTH'(1);
      end else if (state == CLEAR) begin
        cnt   <= cnt + AWIDTH'(1);
        state <= cnt == LAST ? IDLE : CLEAR;
      end
    end
  end
  for (genvar n = 0; n < NREG; n++) begin : g_reg
    if (n == 0) begin : g_zero
      assign regs_flat[WIDTH-1:0] = '0;
    end else begin : g_live
      localparam logic [AWIDTH-1:0] IDX = AWIDTH'(n);
      logic [WIDTH-1:0] q;
      // Clear and write never coincide: clearing only happens while writes are refused
      always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (busy && cnt == IDX) q <= '0;
        else if (wen[n]) q <= wb.wr_data;
      end
      assign regs_flat[n*WIDTH +: WIDTH] = q;
    end
  end
endmodule

// File: tb/tb_regfile_write_decoder.sv
// tb_regfile_write_decoder: directed and random checks against a register-array reference model
module tb_regfile_write_decoder;
  localparam int W = 32;
  localparam int A = 5;
  localparam int N = 32;
  logic         clk = 0;
  logic         reset = 1;
  logic         clr_start = 0;
  logic         busy;
  logic         zero_wr;
  logic [7:0]   wr_count;
  logic [W*N-1:0] regs_flat;
  regfile_write_decoder_if #(.WIDTH(W), .AWIDTH(A)) ifc();
  regfile_write_decoder #(.WIDTH(W), .AWIDTH(A)) dut (
    .clk(clk), .reset(reset), .wb(ifc), .clr_start(clr_start),
    .busy(busy), .zero_wr(zero_wr), .wr_count(wr_count), .regs_flat(regs_flat)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  bit live = 0;
  logic [W-1:0] m [N];
  int m_cnt = 0;
  int m_clr = 0;
  bit m_zw = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] rg(input int i);
    return regs_flat[i*W +: W];
  endfunction
  // Reference: the bank as an array; a clear is "31 cycles remaining", register index derived from it
  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      foreach (m[i]) m[i] = '0;
      m_cnt = 0;
      m_clr = 0;
      m_zw = 0;
    end else begin
      acc = ifc.wr_valid && m_clr == 0;
      m_zw = acc && ifc.wr_addr == 0;
      if (acc && ifc.wr_addr != 0) begin
        m[ifc.wr_addr] = ifc.wr_data;
        if (m_cnt < 255) m_cnt++;
      end
      if (m_clr > 0) begin
        m[N - m_clr] = '0;
        m_clr--;
      end else if (clr_start) m_clr = N - 1;
    end
  end
  always @(negedge clk) begin
    int first;
    if (live) begin
      check("busy", busy, m_clr > 0);
      check("wr_ready", ifc.wr_ready, m_clr == 0);
      check("zero_wr", zero_wr, m_zw);
      check("wr_count", wr_count, m_cnt);
      first = -1;
      for (int i = N - 1; i >= 0; i--) if (rg(i) !== m[i]) first = i;
      if (first < 0) check("regs", 0, 0);
      else check($sformatf("reg%0d", first), rg(first), m[first]);
    end
  end
  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d, output int waits);
    ifc.wr_valid = 1;
    ifc.wr_addr = a;
    ifc.wr_data = d;
    waits = 0;
    while (!ifc.wr_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) check("wr_timeout", 0, 1);
    @(negedge clk);
    ifc.wr_valid = 0;
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("idle_timeout", 0, 1);
  endtask
  initial begin
    int w;
    int bc;
    ifc.wr_valid = 0;
    ifc.wr_addr = '0;
    ifc.wr_data = '0;
    repeat (2) @(posedge clk);
    live = 1;
    @(negedge clk);
    reset = 0;
    check("rst_ready", ifc.wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_regs", regs_flat == '0, 1);
    check("rst_count", wr_count, 0);
    wr(5, 32'hDEADBEEF, w);
    check("r5", rg(5), 32'hDEADBEEF);
    check("r5_count", wr_count, 1);
    check("r5_others", regs_flat == ({{(W*N-W){1'b0}}, 32'hDEADBEEF} << (5*W)), 1);
    wr(0, 32'h12345678, w);
    check("r0_pulse", zero_wr, 1);
    check("r0_value", rg(0), 0);
    check("r0_count", wr_count, 1);
    @(negedge clk);
    check("r0_pulse_end", zero_wr, 0);
    for (int n = 1; n < N; n++) wr(A'(n), W'(n), w);
    check("fill_r31", rg(31), 31);
    check("fill_count", wr_count, 32);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (bc == 1) check("clr_r1_before", rg(1), 1);
      if (bc == 2) check("clr_r1_first", rg(1), 0);
      if (bc == 31) check("clr_r31_last", rg(31), 31);
      if (bc == 31) check("clr_r30", rg(30), 0);
      @(negedge clk);
    end
    check("busy_len", bc, 31);
    check("clr_all_zero", regs_flat == '0, 1);
    check("clr_count_kept", wr_count, 32);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    wr(7, 32'hA5A5A5A5, w);
    check("held_wait", w, 31);
    check("held_r7", rg(7), 32'hA5A5A5A5);
    clr_start = 1;
    ifc.wr_valid = 1;
    ifc.wr_addr = 3;
    ifc.wr_data = 32'h1;
    @(negedge clk);
    clr_start = 0;
    ifc.wr_valid = 0;
    check("sim_r3_e0", rg(3), 1);
    check("sim_busy", busy, 1);
    @(negedge clk);
    check("sim_r3_e1", rg(3), 1);
    @(negedge clk);
    check("sim_r3_e2", rg(3), 1);
    @(negedge clk);
    check("sim_r3_e3", rg(3), 0);
    wait_idle();
    wr(12, 32'hCAFEF00D, w);
    wr(25, 32'h0BADBEEF, w);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    repeat (9) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ifc.wr_ready, 1);
    check("mid_rst_regs", regs_flat == '0, 1);
    check("mid_rst_count", wr_count, 0);
    for (int c = 0; c < 400; c++) begin
      ifc.wr_valid = $urandom_range(0, 1) == 1;
      ifc.wr_addr = A'($urandom);
      ifc.wr_data = $urandom;
      clr_start = $urandom_range(0, 39) == 0;
      @(negedge clk);
    end
    ifc.wr_valid = 0;
    clr_start = 0;
    @(negedge clk);
    wait_idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    ifc.wr_valid = 1;
    ifc.wr_addr = 9;
    ifc.wr_data = 32'h00000009;
    repeat (300) @(negedge clk);
    ifc.wr_valid = 0;
    check("sat_count", wr_count, 255);
    check("sat_r9", rg(9), 9);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
